alu_ctrl_seq: RTL
=================

Name: alu_ctrl_seq

Overview:
- Second-generation ALU control for the EX stage of the MIPS pipeline.
- Decodes ALUop/funct into a registered ALU select with a wider select field and an extended R-type set (addu, subu, xor, nor, sltu, shifts). Unsupported funct codes are flagged as illegal.
- Adds a sequencer for multi-cycle mult/multu/div/divu. The sequencer launches the multiply/divide unit (MDU), stalls the pipeline for a parametrised latency, then pulses the HI/LO write. A flush aborts an in-flight operation.

Parameters:
- SEL_W, 4: ALU select width. Legal values are 4 or greater; encodings below are zero-extended.
- MDU_LATENCY, 32: cycles the MDU stays busy. Legal values are 2 or greater.
- CNT_W, $clog2(MDU_LATENCY): busy counter width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  instruction present in EX this cycle.
- ALUop  in  2  00 lw/sw, 01 beq, 10 R-type, 11 reserved.
- funct  in  6  IR[5:0].
- flush  in  1  squash the in-flight instruction and abort any MDU operation.
- select  out  SEL_W  registered ALU operation select.
- illegal  out  1  registered: the accepted instruction had an unsupported encoding.
- mdu_start  out  1  one-cycle pulse that launches the MDU.
- mdu_op  out  2  00 mult, 01 multu, 10 div, 11 divu; held while busy.
- stall  out  1  high while the MDU is busy; upstream must hold the instruction.
- hilo_we  out  1  one-cycle pulse when the MDU result is valid.

Behaviour:
- Reset (rst_n low, asynchronous): select=0, illegal=0, mdu_start=0, mdu_op=0, stall=0, hilo_we=0, FSM=IDLE, counter=0.
- Acceptance: accept = valid_in & ~stall & ~flush. All decode outputs register on the rising edge after acceptance (1-cycle latency). If not accepted, select and illegal hold their previous values.
- ALUop decode:
  - 00: select 0010 (add).
  - 01: select 0110 (sub).
  - 11: illegal=1, select 1111.
  - 10: decode funct as below.
- R-type funct decode:
  - 100000 or 100001: 0010.
  - 100010 or 100011: 0110.
  - 100100: 0000.
  - 100101: 0001.
  - 100110: 0011.
  - 100111: 1100.
  - 101010: 0111.
  - 101011: 1000.
  - 000000: 1001 (sll).
  - 000010: 1010 (srl).
  - 000011: 1011 (sra).
  - 011000..011011: MDU op, with mdu_op = funct[1:0] and select 0000.
  - Any other funct: illegal=1, select 1111.
- illegal is cleared on every legal accepted instruction.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY: on an accepted MDU op. mdu_start=1 for exactly the next cycle, counter=MDU_LATENCY-1, mdu_op latched, stall=1 from the next cycle.
  - BUSY: counter decrements each cycle. When the counter equals 0 -> DONE. BUSY therefore lasts exactly MDU_LATENCY cycles.
  - DONE: hilo_we=1 and stall=0 for one cycle, then IDLE. An instruction may be accepted in the DONE cycle; an MDU op accepted in DONE goes directly to BUSY.
- stall is a registered output (state==BUSY). valid_in during BUSY is not accepted, and no output changes except the counter.
- flush:
  - In any state: next state IDLE, stall=0, mdu_start=0, hilo_we=0.
  - select and illegal hold their values.
  - flush together with valid_in: the instruction is not accepted.
  - flush in the same cycle the FSM would enter DONE: flush wins, no hilo_we.
- Reset mid-BUSY: all outputs return to reset values immediately. No hilo_we is produced.

Test Plan:
- Reset, then accept ALUop=10 with funct=100111, 100110, 000011 on consecutive cycles -> select 1100, 0011, 1011 one cycle after each; illegal=0 throughout.
- Accept ALUop=10 funct=111111, then ALUop=00 -> illegal=1, select 1111, then illegal=0, select 0010.
- With MDU_LATENCY=32, accept funct=011010 -> mdu_start for 1 cycle, mdu_op=10, stall high for exactly 32 cycles, hilo_we for 1 cycle immediately after; valid_in held high during stall does not change select.
- Back-to-back: accept funct=011000 (mult), then hold valid_in with funct=011011 (divu) -> divu accepted in the DONE cycle; a second mdu_start one cycle after hilo_we; two full 32-cycle stall windows.
- Start mult; assert flush at busy cycle 10 -> stall=0 the next cycle; no hilo_we ever; the FSM accepts a new add immediately, giving select 0010.
- Start div; drop rst_n asynchronously mid-cycle at busy cycle 5 -> stall, mdu_start, hilo_we and select go to 0 without waiting for a clock edge; after release the FSM is IDLE.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// EX-stage ALU control: registered ALUop/funct decode plus a sequencer that
// launches the multiply/divide unit, stalls for its latency and pulses HI/LO write.
module alu_ctrl_seq #(
    parameter int SEL_W       = 4,
    parameter int MDU_LATENCY = 32,
    parameter int CNT_W       = $clog2(MDU_LATENCY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [1:0]       ALUop,
    input  logic [5:0]       funct,
    input  logic             flush,
    output logic [SEL_W-1:0] select,
    output logic             illegal,
    output logic             mdu_start,
    output logic [1:0]       mdu_op,
    output logic             stall,
    output logic             hilo_we,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             is_mdu;
    logic             dec_ill;
    logic [3:0]       dec_code;

    // Handshake: an instruction is consumed on a rising edge where valid_in is
    // high and neither stall nor flush is; upstream holds it while stall is high.
    assign accept = valid_in & ~stall & ~flush;

    always_comb begin
        dec_code = 4'b1111;
        dec_ill  = 1'b1;
        is_mdu   = 1'b0;
        case (ALUop)
            2'b00: begin dec_code = 4'b0010; dec_ill = 1'b0; end
            2'b01: begin dec_code = 4'b0110; dec_ill = 1'b0; end
            2'b10: begin
                dec_ill = 1'b0;
                case (funct)
                    6'b100000, 6'b100001: dec_code = 4'b0010;
                    6'b100010, 6'b100011: dec_code = 4'b0110;
                    6'b100100:            dec_code = 4'b0000;
                    6'b100101:            dec_code = 4'b0001;
                    6'b100110:            dec_code = 4'b0011;
                    6'b100111:            dec_code = 4'b1100;
                    6'b101010:            dec_code = 4'b0111;
                    6'b101011:            dec_code = 4'b1000;
                    6'b000000:            dec_code = 4'b1001;
                    6'b000010:            dec_code = 4'b1010;
                    6'b000011:            dec_code = 4'b1011;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
                        dec_code = 4'b0000;
                        is_mdu   = 1'b1;
                    end
                    default: begin
                        dec_code = 4'b1111;
                        dec_ill  = 1'b1;
                    end
                endcase
            end
            default: begin dec_code = 4'b1111; dec_ill = 1'b1; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept && is_mdu) state_nxt = BUSY;
                BUSY:    if (cnt == '0) state_nxt = DONE;
                DONE:    state_nxt = (accept && is_mdu) ? BUSY : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        stall     = (state == BUSY);
        hilo_we   = (state == DONE);
        fsm_state = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            select    <= '0;
            illegal   <= 1'b0;
            mdu_start <= 1'b0;
            mdu_op    <= 2'b00;
            cnt       <= '0;
        end else begin
            mdu_start <= accept & is_mdu;
            if (accept) begin
                select  <= SEL_W'(dec_code);
                illegal <= dec_ill;
                if (is_mdu) mdu_op <= funct[1:0];
            end
            // Counter loads L-1 so BUSY spans exactly MDU_LATENCY cycles.
            if (flush)                         cnt <= '0;
            else if (accept && is_mdu)         cnt <= CNT_W'(MDU_LATENCY - 1);
            else if (state == BUSY && cnt != '0) cnt <= cnt - 1'b1;
        end
    end

endmodule
